if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
- Parametrised instruction-fetch front end. Owns the PC register, a synchronous-read instruction memory and a prefetch queue of {pc, instruction, fault} entries.
- Delivers entries to decode over a valid/ready handshake, replacing the fixed IF_ID write-enable scheme.
- Supports redirect (branch/jump/trap flush) and precise fetch-fault reporting.
- Sits between the PC-select logic and the decode stage.

Parameters:
- XLEN, 64: PC/address width.
- ILEN, 32: instruction width.
- IMEM_DEPTH, 1024: instruction memory depth in words; power of two, at least 2.
- FIFO_DEPTH, 4: prefetch queue entries; power of two, at least 2.
- RESET_PC, 0: PC value after reset.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- imem_we  input  1  instruction memory write enable (program load).
- imem_waddr  input  log2(IMEM_DEPTH)  word index to write.
- imem_wdata  input  ILEN  write data.
- redirect_valid  input  1  flush the queue and restart fetch at redirect_pc.
- redirect_pc  input  XLEN  new fetch PC.
- out_ready  input  1  decode accepts the head entry.
- out_valid  output  1  head entry is valid.
- out_pc  output  XLEN  PC of the head entry.
- out_instr  output  ILEN  instruction of the head entry.
- out_fault  output  1  head entry is a fetch fault.
- fetch_pc  output  XLEN  current PC register.
- halted  output  1  high when in the FAULT state.

Behaviour:
- **Reset** (async): PC=RESET_PC, FIFO empty, F1 stage invalid, state=RUN.
  - Outputs: out_valid=0, out_pc=0, out_instr=0, out_fault=0, halted=0, fetch_pc=RESET_PC.
  - Memory contents are not reset.
- **Pipeline:**
  - Stage F1: a register that captures {pc, mem[pc word], fault} on the issue edge.
  - Following edge: F1 pushes into the FIFO.
  - FIFO output is registered/non-bypass; out_* reflect the FIFO head.
- **Issue condition:**
  - Issue occurs when state=RUN, redirect_valid=0, and (FIFO count + F1 valid − pop this cycle) < FIFO_DEPTH.
  - On issue, PC <= PC+4.
  - The FIFO therefore never overflows and no entry is dropped.
- **Latency:**
  - First edge after reset release issues RESET_PC.
  - out_valid is high after the second edge.
  - Steady state: one entry per cycle while out_ready=1.
- **Fault detect:**
  - Fault condition: PC[1:0]!=0 or PC[XLEN-1:2] >= IMEM_DEPTH.
  - A faulting PC is issued as an entry with fault=1 and instr=32'h00000013 (NOP). The memory is not read.
  - State goes to FAULT; no further issue; PC holds; halted=1.
  - Entries already queued drain normally.
- **State machine:**
  - RUN -> FAULT on a faulting issue.
  - FAULT -> RUN only on redirect_valid.
  - Redirect in RUN: stays in RUN.
- **Handshake:**
  - Pop when out_valid && out_ready.
  - out_* are held stable while out_valid=1 and out_ready=0.
  - Push and pop in the same cycle are allowed at any count, including full.
- **Redirect** (sampled at edge N):
  - FIFO cleared, F1 invalidated, PC <= redirect_pc, state <= RUN, no issue at N.
  - out_valid=0 after N.
  - redirect_pc is issued at N+1; its entry is visible after N+2.
  - Redirect has priority over issue and push.
  - A pop in the same cycle counts as consumed; the remaining entries are discarded anyway.
  - A misaligned or out-of-range redirect_pc produces a fault entry at N+2.
- **Memory write:**
  - Synchronous write on imem_we.
  - Read and write to the same word in the same cycle: the read returns old data.
- **Wrap:**
  - PC+4 wraps modulo 2^XLEN.
  - Reaching word IMEM_DEPTH faults rather than wrapping the memory index.
  - FIFO pointers wrap modulo FIFO_DEPTH; full and empty are distinguished by a count or an extra pointer bit.
- **Reset mid-operation:** immediate return to the reset state. Queued entries and F1 are lost.

Test Plan:
- **Streaming:** load mem[0..7]=0x100+i, RESET_PC=0, out_ready=1 -> out_valid first high after edge 2; pc 0,4,8,... with instr 0x100,0x101,..., one per cycle, out_fault=0.
- **Backpressure:** out_ready=0 for 10 cycles -> exactly FIFO_DEPTH entries held; head pc=0 stable; release -> pcs 0..0x1C in order with no gaps or duplicates.
- **Redirect with a full FIFO:** redirect_valid with redirect_pc=0x40 -> out_valid=0 next cycle; after two more edges head pc=0x40, instr=mem[16]; no stale entries.
- **Misaligned redirect:** redirect_pc=0x42 -> entry pc=0x42, out_fault=1, instr=0x00000013; halted=1; fetch_pc stays 0x42; a later redirect to 0x0 resumes fetch.
- **End of memory:** PC runs to 4*IMEM_DEPTH-4 then 4*IMEM_DEPTH -> last valid word delivered, then a fault entry at pc=0x1000 (default depth), then halt.
- **Async reset:** assert rst mid-stream between edges -> outputs reset immediately, before the next edge; restart delivers pc=RESET_PC first.

Source files
------------

// File: rtl/if_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_fetch_queue
//
// Instruction-fetch front end: owns the PC register, a synchronous-read
// instruction memory and a small prefetch queue of {pc, instr, fault}
// entries. Entries are delivered to decode over a valid/ready handshake.
// A redirect flushes everything in flight and restarts fetch at a new PC.
// A misaligned or out-of-range PC produces one fault entry (instr = NOP).
// Fetch then halts until the next redirect.
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   imem_we/waddr/   synchronous program-load write port into the
//   imem_wdata       instruction memory
//   redirect_valid/  flush the queue and restart fetch at redirect_pc
//   redirect_pc
//   out_ready        decode accepts the head entry this cycle
//   out_valid/pc/    head entry of the prefetch queue (all zero when empty)
//   instr/fault
//   fetch_pc         current PC register
//   halted           high while fetch is stopped on a fault
// ---------------------------------------------------------------------------
module if_fetch_queue #(
    parameter int XLEN       = 64,
    parameter int ILEN       = 32,
    parameter int IMEM_DEPTH = 1024,
    parameter int FIFO_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [ILEN-1:0]               imem_wdata,
    input  logic                          redirect_valid,
    input  logic [XLEN-1:0]               redirect_pc,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [XLEN-1:0]               out_pc,
    output logic [ILEN-1:0]               out_instr,
    output logic                          out_fault,
    output logic [XLEN-1:0]               fetch_pc,
    output logic                          halted
);

    localparam int IDX_W = $clog2(IMEM_DEPTH);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ILEN-1:0] NOP_INSTR = ILEN'(32'h0000_0013);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    state_t            state_q;
    logic [XLEN-1:0]   fetchPc_q;

    // F1 stage: PC and fault flag are captured here; the instruction word
    // comes from the memory's own output register captured on the same edge.
    logic              f1Valid_q;
    logic [XLEN-1:0]   f1Pc_q;
    logic              f1Fault_q;
    logic [ILEN-1:0]   memRdata_q;
    logic [ILEN-1:0]   f1Instr;

    logic [ILEN-1:0]   imem [IMEM_DEPTH];

    logic [XLEN-1:0]   fifoPc    [FIFO_DEPTH];
    logic [ILEN-1:0]   fifoInstr [FIFO_DEPTH];
    logic              fifoFault [FIFO_DEPTH];
    logic [PTR_W-1:0]  rdPtr_q;
    logic [PTR_W-1:0]  wrPtr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic [CNT_W:0]    occupancy;

    logic              headValid;
    logic              pcFault;
    logic              issue;
    logic              push;
    logic              pop;
    logic [IDX_W-1:0]  pcIdx;

    assign headValid = (count_q != '0);
    assign pop       = headValid && out_ready;
    assign push      = f1Valid_q && !redirect_valid;
    assign pcIdx     = fetchPc_q[IDX_W+1:2];

    // Anything at or beyond word IMEM_DEPTH faults instead of aliasing
    // back onto the start of memory.
    assign pcFault = (fetchPc_q[1:0] != 2'b00) || ((fetchPc_q >> (IDX_W + 2)) != '0);

    // Entries already in the queue plus the one in F1, less the one leaving
    // this cycle; an issue is only allowed if that leaves room, so the entry
    // pushed on the next edge always fits.
    assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, f1Valid_q} - {{CNT_W{1'b0}}, pop};
    assign issue     = (state_q == RUN) && !redirect_valid
                       && (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
    assign count_d   = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};

    assign f1Instr   = f1Fault_q ? NOP_INSTR : memRdata_q;

    // Instruction memory: the non-blocking write means a same-cycle read of
    // the same word sees the old contents. A faulting PC never reads.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem[imem_waddr] <= imem_wdata;
        end
        if (issue && !pcFault) begin
            memRdata_q <= imem[pcIdx];
        end
    end

    // Queue storage has no reset; the outputs are gated by the count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoPc[wrPtr_q]    <= f1Pc_q;
            fifoInstr[wrPtr_q] <= f1Instr;
            fifoFault[wrPtr_q] <= f1Fault_q;
        end
    end

    // Fetch control and state machine. Redirect beats issue and push: it
    // empties the queue, kills F1 and reloads the PC without issuing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            fetchPc_q <= RESET_PC;
            f1Valid_q <= 1'b0;
            f1Pc_q    <= '0;
            f1Fault_q <= 1'b0;
            rdPtr_q   <= '0;
            wrPtr_q   <= '0;
            count_q   <= '0;
        end else if (redirect_valid) begin
            state_q   <= RUN;
            fetchPc_q <= redirect_pc;
            f1Valid_q <= 1'b0;
            rdPtr_q   <= '0;
            wrPtr_q   <= '0;
            count_q   <= '0;
        end else begin
            f1Valid_q <= issue;
            if (issue) begin
                f1Pc_q    <= fetchPc_q;
                f1Fault_q <= pcFault;
                if (pcFault) begin
                    state_q <= FAULT;
                end else begin
                    fetchPc_q <= fetchPc_q + XLEN'(4);
                end
            end
            if (push) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    assign out_valid = headValid;
    assign out_pc    = headValid ? fifoPc[rdPtr_q]    : '0;
    assign out_instr = headValid ? fifoInstr[rdPtr_q] : '0;
    assign out_fault = headValid ? fifoFault[rdPtr_q] : 1'b0;
    assign fetch_pc  = fetchPc_q;
    assign halted    = (state_q == FAULT);

endmodule

// File: tb/tb_if_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_queue
//
// Self-checking bench for if_fetch_queue with default parameters. A table of
// per-cycle vectors covers start-up latency and backpressure. Hand-written
// sequences cover redirect, fault, end-of-memory and async reset. Every
// entry accepted by decode is checked against a queue of expected entries
// filled in whenever the bench starts a new fetch stream.
// ---------------------------------------------------------------------------
module tb_if_fetch_queue;

    localparam int XLEN       = 64;
    localparam int ILEN       = 32;
    localparam int IMEM_DEPTH = 1024;
    localparam int FIFO_DEPTH = 4;
    localparam int IDX_W      = 10;

    logic              clk;
    logic              rst;
    logic              imem_we;
    logic [IDX_W-1:0]  imem_waddr;
    logic [ILEN-1:0]   imem_wdata;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic              out_ready;
    logic              out_valid;
    logic [XLEN-1:0]   out_pc;
    logic [ILEN-1:0]   out_instr;
    logic              out_fault;
    logic [XLEN-1:0]   fetch_pc;
    logic              halted;

    typedef struct {
        logic            ready;
        logic            expValid;
        logic [63:0]     expPc;
        logic [31:0]     expInstr;
        logic [63:0]     expFetchPc;
    } vec_t;

    typedef struct {
        logic [63:0]     pc;
        logic [31:0]     instr;
        logic            fault;
    } entry_t;

    vec_t        vecs [17];
    entry_t      expQ [$];
    entry_t      head;
    logic [31:0] memModel [IMEM_DEPTH];
    int          nCompared;
    int          nMismatched;

    if_fetch_queue #(
        .XLEN       (XLEN),
        .ILEN       (ILEN),
        .IMEM_DEPTH (IMEM_DEPTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .RESET_PC   (64'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_we        (imem_we),
        .imem_waddr     (imem_waddr),
        .imem_wdata     (imem_wdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_ready      (out_ready),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_fault      (out_fault),
        .fetch_pc       (fetch_pc),
        .halted         (halted)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive inputs for the coming edge, then return 1 time unit after it.
    task automatic applyStimulus(input logic ready, input logic redir,
                                 input logic [63:0] rpc);
        out_ready      = ready;
        redirect_valid = redir;
        redirect_pc    = rpc;
        @(posedge clk);
        #1;
    endtask

    task automatic loadWord(input int idx, input logic [31:0] data);
        imem_we    = 1'b1;
        imem_waddr = IDX_W'(idx);
        imem_wdata = data;
        memModel[idx] = data;
        @(posedge clk);
        #1;
        imem_we = 1'b0;
    endtask

    task automatic pushStream(input logic [63:0] startPc, input int n);
        entry_t e;
        for (int i = 0; i < n; i++) begin
            e.pc    = startPc + 64'(4 * i);
            e.instr = memModel[e.pc[11:2]];
            e.fault = 1'b0;
            expQ.push_back(e);
        end
    endtask

    task automatic pushFault(input logic [63:0] pc);
        entry_t e;
        e.pc    = pc;
        e.instr = 32'h0000_0013;
        e.fault = 1'b1;
        expQ.push_back(e);
    endtask

    // Scoreboard: every handshake seen at the falling edge consumes one
    // expected entry.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                nCompared++;
                nMismatched++;
                $display("[TB] FAIL sb unexpected entry: got pc 0x%0h, expected none", out_pc);
            end else begin
                head = expQ.pop_front();
                checkOutput("sb pc", out_pc, head.pc);
                checkOutput("sb instr", 64'(out_instr), 64'(head.instr));
                checkOutput("sb fault", 64'(out_fault), 64'(head.fault));
            end
        end
    end

    // Safety net in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        nCompared      = 0;
        nMismatched    = 0;
        rst            = 1'b1;
        imem_we        = 1'b0;
        imem_waddr     = '0;
        imem_wdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;

        // Start-up and backpressure: out_ready low for 10 cycles, then high.
        vecs[0] = '{1'b0, 1'b0, 64'h0, 32'h0,   64'h4};
        vecs[1] = '{1'b0, 1'b1, 64'h0, 32'h100, 64'h8};
        vecs[2] = '{1'b0, 1'b1, 64'h0, 32'h100, 64'hC};
        vecs[3] = '{1'b0, 1'b1, 64'h0, 32'h100, 64'h10};
        for (int i = 4; i < 10; i++) begin
            vecs[i] = '{1'b0, 1'b1, 64'h0, 32'h100, 64'h10};
        end
        for (int i = 10; i < 17; i++) begin
            vecs[i] = '{1'b1, 1'b1, 64'(4 * (i - 9)), 32'(32'h100 + (i - 9)),
                        64'(4 * (i - 9) + 16)};
        end

        // Program load while held in reset.
        #2;
        for (int i = 0; i < 32; i++) begin
            loadWord(i, 32'h100 + 32'(i));
        end
        for (int i = 1020; i < 1024; i++) begin
            loadWord(i, 32'hA00 + 32'(i - 1020));
        end

        checkOutput("reset out_valid", 64'(out_valid), 64'h0);
        checkOutput("reset out_pc", out_pc, 64'h0);
        checkOutput("reset out_instr", 64'(out_instr), 64'h0);
        checkOutput("reset out_fault", 64'(out_fault), 64'h0);
        checkOutput("reset halted", 64'(halted), 64'h0);
        checkOutput("reset fetch_pc", fetch_pc, 64'h0);

        rst = 1'b0;
        pushStream(64'h0, 32);
        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].ready, 1'b0, 64'h0);
            checkOutput($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(vecs[i].expValid));
            if (vecs[i].expValid) begin
                checkOutput($sformatf("vec%0d out_pc", i), out_pc, vecs[i].expPc);
                checkOutput($sformatf("vec%0d out_instr", i), 64'(out_instr), 64'(vecs[i].expInstr));
            end
            checkOutput($sformatf("vec%0d fetch_pc", i), fetch_pc, vecs[i].expFetchPc);
        end

        // Fill the queue, then redirect to 0x40.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b0, 64'h0);
        end
        checkOutput("full out_pc", out_pc, 64'h1C);
        checkOutput("full fetch_pc", fetch_pc, 64'h2C);
        applyStimulus(1'b0, 1'b1, 64'h40);
        expQ.delete();
        pushStream(64'h40, 16);
        checkOutput("redir N out_valid", 64'(out_valid), 64'h0);
        checkOutput("redir N fetch_pc", fetch_pc, 64'h40);
        applyStimulus(1'b0, 1'b0, 64'h0);
        checkOutput("redir N+1 out_valid", 64'(out_valid), 64'h0);
        checkOutput("redir N+1 fetch_pc", fetch_pc, 64'h44);
        applyStimulus(1'b0, 1'b0, 64'h0);
        checkOutput("redir N+2 out_valid", 64'(out_valid), 64'h1);
        checkOutput("redir N+2 out_pc", out_pc, 64'h40);
        checkOutput("redir N+2 out_instr", 64'(out_instr), 64'h110);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 64'h0);
        end

        // Misaligned redirect: a single fault entry, then halt.
        applyStimulus(1'b1, 1'b1, 64'h42);
        expQ.delete();
        pushFault(64'h42);
        checkOutput("misal N out_valid", 64'(out_valid), 64'h0);
        checkOutput("misal N halted", 64'(halted), 64'h0);
        applyStimulus(1'b0, 1'b0, 64'h0);
        checkOutput("misal N+1 halted", 64'(halted), 64'h1);
        checkOutput("misal N+1 fetch_pc", fetch_pc, 64'h42);
        applyStimulus(1'b0, 1'b0, 64'h0);
        checkOutput("misal N+2 out_valid", 64'(out_valid), 64'h1);
        checkOutput("misal N+2 out_pc", out_pc, 64'h42);
        checkOutput("misal N+2 out_fault", 64'(out_fault), 64'h1);
        checkOutput("misal N+2 out_instr", 64'(out_instr), 64'h13);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 64'h0);
        end
        checkOutput("misal hold out_pc", out_pc, 64'h42);
        applyStimulus(1'b1, 1'b0, 64'h0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 64'h0);
        end
        checkOutput("misal drained out_valid", 64'(out_valid), 64'h0);
        checkOutput("misal still halted", 64'(halted), 64'h1);
        checkOutput("misal fetch_pc held", fetch_pc, 64'h42);
        checkOutput("misal sb empty", 64'(expQ.size()), 64'h0);

        // Resume at 0.
        applyStimulus(1'b1, 1'b1, 64'h0);
        expQ.delete();
        pushStream(64'h0, 32);
        checkOutput("resume halted", 64'(halted), 64'h0);
        checkOutput("resume fetch_pc", fetch_pc, 64'h0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 64'h0);
        end

        // End of memory: last four words, then a fault at 0x1000.
        applyStimulus(1'b1, 1'b1, 64'hFF0);
        expQ.delete();
        pushStream(64'hFF0, 4);
        pushFault(64'h1000);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 1'b0, 64'h0);
        end
        checkOutput("eom halted", 64'(halted), 64'h1);
        checkOutput("eom fetch_pc", fetch_pc, 64'h1000);
        checkOutput("eom out_valid", 64'(out_valid), 64'h0);
        checkOutput("eom sb empty", 64'(expQ.size()), 64'h0);

        // Async reset in the middle of a stream.
        applyStimulus(1'b1, 1'b1, 64'h0);
        expQ.delete();
        pushStream(64'h0, 32);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b0, 64'h0);
        end
        checkOutput("pre-rst out_valid", 64'(out_valid), 64'h1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async rst out_valid", 64'(out_valid), 64'h0);
        checkOutput("async rst out_pc", out_pc, 64'h0);
        checkOutput("async rst fetch_pc", fetch_pc, 64'h0);
        checkOutput("async rst halted", 64'(halted), 64'h0);
        expQ.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        pushStream(64'h0, 32);
        applyStimulus(1'b1, 1'b0, 64'h0);
        checkOutput("restart edge1 out_valid", 64'(out_valid), 64'h0);
        applyStimulus(1'b1, 1'b0, 64'h0);
        checkOutput("restart edge2 out_valid", 64'(out_valid), 64'h1);
        checkOutput("restart edge2 out_pc", out_pc, 64'h0);
        checkOutput("restart edge2 out_instr", 64'(out_instr), 64'h100);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b0, 64'h0);
        end
        applyStimulus(1'b0, 1'b0, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
